// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM encodings and mem size-select constants shared with mem and cpu.
package mem_arbiter_pkg;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam logic [2:0] SEL_BYTE = 3'd0;
    localparam logic [2:0] SEL_HALF = 3'd1;
    localparam logic [2:0] SEL_WORD = 3'd2;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// mem_arbiter_rr_pick: combinational round-robin pick of the first pending channel after last.
module mem_arbiter_rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int N_CH = 2,
    localparam int IW = idx_w(N_CH)
) (
    input  logic [N_CH-1:0] pend,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   idx
);
    // Walk from farthest to nearest so the nearest pending channel after last wins.
    always_comb begin
        valid = 1'b0;
        idx = '0;
        for (int i = N_CH; i >= 1; i--) begin
            if (pend[IW'((int'(last) + i) % N_CH)]) begin
                valid = 1'b1;
                idx = IW'((int'(last) + i) % N_CH);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one mem port among N_CH exec/fin/busy masters,
// with per-channel request buffers and an optional watchdog that aborts hung transactions.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = 3,
    parameter int TIMEOUT = 0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [N_CH-1:0]    i_m_exec,
    input  logic [N_CH*AW-1:0] i_m_addr,
    input  logic [N_CH*DW-1:0] i_m_data,
    input  logic [N_CH*SW-1:0] i_m_sel,
    input  logic [N_CH-1:0]    i_m_we,
    output logic [DW-1:0]      o_m_data,
    output logic [N_CH-1:0]    o_m_fin,
    output logic [N_CH-1:0]    o_m_err,
    output logic [N_CH-1:0]    o_m_busy,
    output logic               o_s_exec,
    output logic [AW-1:0]      o_s_addr,
    output logic [DW-1:0]      o_s_data,
    output logic [SW-1:0]      o_s_sel,
    output logic               o_s_we,
    input  logic [DW-1:0]      i_s_data,
    input  logic               i_s_fin,
    input  logic               i_s_busy
);
    localparam int IW = idx_w(N_CH);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    logic [AW-1:0] addr_q [N_CH];
    logic [DW-1:0] data_q [N_CH];
    logic [SW-1:0] sel_q  [N_CH];
    logic [N_CH-1:0] we_q;
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] to_q;
    logic [IW-1:0] last;
    logic [IW-1:0] g;
    logic [IW-1:0] pick;
    logic pick_valid;
    logic [0:0] state;
    logic [CW-1:0] cnt;
    logic done_ok;
    logic to_hit;

    mem_arbiter_rr_pick #(.N_CH(N_CH)) u_pick (
        .pend  (pend),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick)
    );

    assign done_ok = state == ST_WAIT && i_s_fin;
    // A fin arriving in the timeout cycle takes priority over the abort.
    assign to_hit = TIMEOUT != 0 && state == ST_WAIT && cnt == CW'(TIMEOUT - 1) && !i_s_fin;
    assign o_m_data = done_ok ? i_s_data : '0;
    assign o_m_fin = (N_CH'(done_ok) << g) | to_q;
    assign o_m_err = to_q;
    assign o_m_busy = pend;

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (i_m_exec[k] && !pend[k]) begin
                addr_q[k] <= i_m_addr[k*AW +: AW];
                data_q[k] <= i_m_data[k*DW +: DW];
                sel_q[k] <= i_m_sel[k*SW +: SW];
                we_q[k] <= i_m_we[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
            pend <= '0;
            last <= IW'(N_CH - 1);
            g <= '0;
            cnt <= '0;
            to_q <= '0;
            o_s_exec <= 1'b0;
            o_s_addr <= '0;
            o_s_data <= '0;
            o_s_sel <= '0;
            o_s_we <= 1'b0;
        end else begin
            o_s_exec <= 1'b0;
            to_q <= '0;
            for (int k = 0; k < N_CH; k++)
                if (i_m_exec[k] && !pend[k]) pend[k] <= 1'b1;
            if (state == ST_IDLE) begin
                if (pick_valid && !i_s_busy) begin
                    g <= pick;
                    last <= pick;
                    o_s_addr <= addr_q[pick];
                    o_s_data <= data_q[pick];
                    o_s_sel <= sel_q[pick];
                    o_s_we <= we_q[pick];
                    o_s_exec <= 1'b1;
                    cnt <= '0;
                    state <= ST_WAIT;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (i_s_fin || to_hit) begin
                    pend[g] <= 1'b0;
                    to_q <= N_CH'(to_hit) << g;
                    state <= ST_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with two channels and an 8-cycle watchdog.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  m_exec = '0;
    logic [63:0] m_addr = '0;
    logic [63:0] m_data = '0;
    logic [5:0]  m_sel = '0;
    logic [1:0]  m_we = '0;
    logic [31:0] o_m_data;
    logic [1:0]  o_m_fin;
    logic [1:0]  o_m_err;
    logic [1:0]  o_m_busy;
    logic        o_s_exec;
    logic [31:0] o_s_addr;
    logic [31:0] o_s_data;
    logic [2:0]  o_s_sel;
    logic        o_s_we;
    logic [31:0] s_data = '0;
    logic        s_fin = 1'b0;
    logic        s_busy = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.N_CH(2), .AW(32), .DW(32), .SW(3), .TIMEOUT(8)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_m_exec  (m_exec),
        .i_m_addr  (m_addr),
        .i_m_data  (m_data),
        .i_m_sel   (m_sel),
        .i_m_we    (m_we),
        .o_m_data  (o_m_data),
        .o_m_fin   (o_m_fin),
        .o_m_err   (o_m_err),
        .o_m_busy  (o_m_busy),
        .o_s_exec  (o_s_exec),
        .o_s_addr  (o_s_addr),
        .o_s_data  (o_s_data),
        .o_s_sel   (o_s_sel),
        .o_s_we    (o_s_we),
        .i_s_data  (s_data),
        .i_s_fin   (s_fin),
        .i_s_busy  (s_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int ch, input logic [31:0] a, input logic we, input logic [31:0] d);
        m_exec[ch] = 1'b1;
        m_addr[ch*32 +: 32] = a;
        m_data[ch*32 +: 32] = d;
        m_sel[ch*3 +: 3] = SEL_WORD;
        m_we[ch] = we;
    endtask

    // Starts one edge before the expected issue; ends just after the fin edge.
    task automatic serve(input logic [31:0] a, input logic [1:0] f, input logic [31:0] d);
        tick();
        chk("issue", {63'd0, o_s_exec}, 64'd1);
        chk("issue_addr", {32'd0, o_s_addr}, {32'd0, a});
        tick();
        chk("exec_pulse", {63'd0, o_s_exec}, 64'd0);
        chk("addr_hold", {32'd0, o_s_addr}, {32'd0, a});
        s_fin = 1'b1;
        s_data = d;
        #1;
        chk("fin", {62'd0, o_m_fin}, {62'd0, f});
        chk("rdata", {32'd0, o_m_data}, {32'd0, d});
        chk("no_err", {62'd0, o_m_err}, 64'd0);
        tick();
        s_fin = 1'b0;
        s_data = '0;
        #1;
        chk("fin_clr", {62'd0, o_m_fin}, 64'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", {62'd0, o_m_busy}, 64'd0);
        chk("rst_exec", {63'd0, o_s_exec}, 64'd0);
        chk("rst_fin", {62'd0, o_m_fin}, 64'd0);
        chk("rst_addr", {32'd0, o_s_addr}, 64'd0);
        rst_n = 1'b1;
        // single read on ch0
        req(0, 32'h10, 1'b0, 32'h0);
        tick();
        m_exec = '0;
        chk("t1_busy", {62'd0, o_m_busy}, 64'd1);
        chk("t1_noexec", {63'd0, o_s_exec}, 64'd0);
        serve(32'h10, 2'b01, 32'hDEADBEEF);
        chk("t1_busy_clr", {62'd0, o_m_busy}, 64'd0);
        // contention from a fresh reset: 0,1,0,1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req(0, 32'h100, 1'b0, 32'h0);
        req(1, 32'h200, 1'b0, 32'h0);
        tick();
        m_exec = '0;
        chk("t2_busy", {62'd0, o_m_busy}, 64'd3);
        serve(32'h100, 2'b01, 32'h1111);
        serve(32'h200, 2'b10, 32'h2222);
        req(0, 32'h110, 1'b0, 32'h0);
        req(1, 32'h210, 1'b0, 32'h0);
        tick();
        m_exec = '0;
        serve(32'h110, 2'b01, 32'h3333);
        serve(32'h210, 2'b10, 32'h4444);
        // mem busy holds off issue
        s_busy = 1'b1;
        req(1, 32'h300, 1'b0, 32'h0);
        tick();
        m_exec = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_held", {63'd0, o_s_exec}, 64'd0);
        end
        s_busy = 1'b0;
        serve(32'h300, 2'b10, 32'h5555);
        // re-exec while pending is ignored
        req(0, 32'h400, 1'b1, 32'h55);
        tick();
        m_exec = '0;
        s_busy = 1'b1;
        req(0, 32'h500, 1'b0, 32'h99);
        tick();
        m_exec = '0;
        s_busy = 1'b0;
        chk("t4_busy", {62'd0, o_m_busy}, 64'd1);
        serve(32'h400, 2'b01, 32'h0);
        chk("t4_we", {63'd0, o_s_we}, 64'd1);
        chk("t4_wdata", {32'd0, o_s_data}, 64'h55);
        chk("t4_sel", {61'd0, o_s_sel}, {61'd0, SEL_WORD});
        chk("t4_busy_clr", {62'd0, o_m_busy}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_reissue", {63'd0, o_s_exec}, 64'd0);
        end
        // watchdog abort on ch1, then ch0 is serviced
        req(0, 32'h700, 1'b0, 32'h0);
        req(1, 32'h600, 1'b0, 32'h0);
        tick();
        m_exec = '0;
        tick();
        chk("t5_issue", {63'd0, o_s_exec}, 64'd1);
        chk("t5_addr", {32'd0, o_s_addr}, 64'h600);
        s_data = 32'h1234;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t5_wait_fin", {62'd0, o_m_fin}, 64'd0);
            chk("t5_wait_err", {62'd0, o_m_err}, 64'd0);
        end
        tick();
        chk("t5_to_fin", {62'd0, o_m_fin}, 64'd2);
        chk("t5_to_err", {62'd0, o_m_err}, 64'd2);
        chk("t5_to_data", {32'd0, o_m_data}, 64'd0);
        chk("t5_to_busy", {62'd0, o_m_busy}, 64'd1);
        s_data = '0;
        serve(32'h700, 2'b01, 32'hBEEF);
        // fin in the timeout cycle wins
        req(1, 32'h800, 1'b0, 32'h0);
        tick();
        m_exec = '0;
        tick();
        chk("t5b_issue", {63'd0, o_s_exec}, 64'd1);
        for (int i = 0; i < 7; i++) tick();
        s_fin = 1'b1;
        s_data = 32'hCAFE;
        #1;
        chk("t5b_fin", {62'd0, o_m_fin}, 64'd2);
        chk("t5b_err", {62'd0, o_m_err}, 64'd0);
        chk("t5b_data", {32'd0, o_m_data}, 64'hCAFE);
        tick();
        s_fin = 1'b0;
        s_data = '0;
        #1;
        chk("t5b_fin_clr", {62'd0, o_m_fin}, 64'd0);
        chk("t5b_err_clr", {62'd0, o_m_err}, 64'd0);
        chk("t5b_busy", {62'd0, o_m_busy}, 64'd0);
        // reset while in WAIT drops everything
        req(0, 32'h900, 1'b0, 32'h0);
        tick();
        m_exec = '0;
        tick();
        chk("t6_issue", {63'd0, o_s_exec}, 64'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {62'd0, o_m_busy}, 64'd0);
        chk("t6_rst_addr", {32'd0, o_s_addr}, 64'd0);
        tick();
        rst_n = 1'b1;
        s_fin = 1'b1;
        s_data = 32'h77;
        #1;
        chk("t6_late_fin", {62'd0, o_m_fin}, 64'd0);
        tick();
        s_fin = 1'b0;
        s_data = '0;
        #1;
        chk("t6_fin_clr", {62'd0, o_m_fin}, 64'd0);
        chk("t6_busy", {62'd0, o_m_busy}, 64'd0);
        req(1, 32'hA00, 1'b0, 32'h0);
        tick();
        m_exec = '0;
        serve(32'hA00, 2'b10, 32'h5A5A);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
